ccu_clk_sched: RTL and testbench
================================

Name: ccu_clk_sched

Overview:
- RTL clock-control scheduler that serves per-slice clkreq/clkack handshakes for NUM_SLICES clock slices.
- Drives a gate-enable per slice and sequences every gate/ungate transition with programmed inter-edge delays (req1->clk1, clk1->ack1, req0->ack0, ack0->clk0).
- One shared sequencer serves all slices; a round-robin arbiter picks which slice transitions next.
- Also generates the periodic globalusync pulse and the per-slice usync pulses.

Parameters:
- NUM_SLICES, 4: number of clock slices, range 1..32.
- REQ1_CLK1_DLY, 2: cycles from request accepted to clk_en high; must be >= 1.
- CLK1_ACK1_DLY, 2: cycles from clk_en high to clkack high; must be >= 1.
- REQ0_ACK0_DLY, 2: cycles from deassert accepted to clkack low; must be >= 1.
- ACK0_CLK0_DLY, 8: cycles from clkack low to clk_en low; must be >= 1.
- USYNC_PERIOD, 16: globalusync period in cycles; must be >= 2.
- CNT_W, 8: delay counter width; every DLY must be < 2**CNT_W.

Ports:
- clk, in, 1: free-running reference clock.
- rst_b, in, 1: reset, asynchronous assert, active-low.
- clkreq, in, NUM_SLICES: per-slice clock request.
- clkack, out, NUM_SLICES: per-slice clock acknowledge.
- clk_en, out, NUM_SLICES: per-slice gate enable; 1 = clock running.
- usync, out, NUM_SLICES: per-slice usync pulse.
- globalusync, out, 1: global usync pulse.
- busy, out, 1: sequencer not IDLE.
- active_slice, out, $clog2(NUM_SLICES) (min 1): index of the slice being sequenced; 0 when idle.

Behaviour:
- Reset: clkack=0, clk_en=0, usync=0, globalusync=0, busy=0, active_slice=0, state=IDLE, rr pointer=0, usync counter=0. Async assert works mid-transition; the in-flight transition is abandoned and all clocks are gated.
- Pending vector: pend = clkreq ^ clkack. clkreq is sampled directly with no synchronizer; callers supply clkreq synchronous to clk.
- Arbitration, IDLE only: grant the first set pend bit searching from ptr upward with wrap. After grant, ptr = granted+1 mod NUM_SLICES. Capture dir = clkreq[s].
- FSM states: IDLE, UNG_WAIT, ACK1_WAIT, ACK0_WAIT, GATE_WAIT.
- IDLE, pend!=0 at edge E0:
  - dir=1 -> UNG_WAIT, cnt=REQ1_CLK1_DLY-1.
  - dir=0 -> ACK0_WAIT, cnt=REQ0_ACK0_DLY-1.
- In every wait state, cnt decrements each edge. Action happens on the edge where cnt==0:
  - UNG_WAIT: clk_en[s]<=1, go ACK1_WAIT, cnt=CLK1_ACK1_DLY-1.
  - ACK1_WAIT: clkack[s]<=1, go IDLE.
  - ACK0_WAIT: clkack[s]<=0, go GATE_WAIT, cnt=ACK0_CLK0_DLY-1.
  - GATE_WAIT: clk_en[s]<=0, go IDLE.
- Latency:
  - Ungate: clk_en high after edge E0+R, clkack high after E0+R+A.
  - Gate: clkack low after E0+R0, clk_en low after E0+R0+C0.
  - Re-arbitration: first possible at the edge following the return to IDLE, giving 1 idle cycle between transitions.
- clkreq change during an in-flight transition of the same slice: the transition completes unchanged; the resulting mismatch re-pends and is re-arbitrated.
- Changes on other slices only affect pend; no preemption.
- Simultaneous requests on all slices: served strictly round-robin; each slice is served at most once per NUM_SLICES grants while others pend.
- Invariants: clkack[s]=1 implies clk_en[s]=1. Outputs change only for active_slice.
- busy=1 in every non-IDLE state.
- usync counter: counts 0..USYNC_PERIOD-1 and wraps. globalusync=1 for exactly the one cycle where counter==USYNC_PERIOD-1 (registered). usync[s]=globalusync & clkack[s], registered together.

Decomposition:
- Package ccu_sched_pkg:
  - state enum ccu_sched_state_e (IDLE, UNG_WAIT, ACK1_WAIT, ACK0_WAIT, GATE_WAIT).
  - function idx_w(n) returning max(1,$clog2(n)).
- Sub-module ccu_sched_rr_arb: combinational round-robin pick.
  - Inputs: pend, ptr.
  - Outputs: gnt_vld, gnt_idx.
  - Parameterized by NUM_SLICES.

Test Plan:
- Defaults: slice 1 clkreq 0->1 at E0 -> busy at E0, clk_en[1] at E0+2, clkack[1] at E0+4, active_slice=1.
- Slice 1 clkreq 1->0 at E0 -> clkack[1] low at E0+2, clk_en[1] low at E0+10, clk_en[1] high throughout E0..E0+9.
- All 4 clkreq rise in one cycle -> grant order 0,1,2,3. Each clkack rises 5 cycles after the previous one (4-cycle sequence plus 1 idle cycle).
- Slice 2 drops clkreq during UNG_WAIT -> clkack[2] still rises at E0+4. A gate sequence then starts at E0+5, clkack[2] low at E0+7, clk_en[2] low at E0+15.
- rst_b asserted in ACK1_WAIT with clk_en[0]=1 -> all outputs 0 immediately, without a clock edge. After release with clkreq[0] still high, a fresh ungate runs.
- USYNC_PERIOD=16, clkack=4'b0101 -> globalusync pulses every 16 cycles, usync[0] and usync[2] pulse in the same cycle, usync[1] and usync[3] stay 0.

Source files
------------

// File: rtl/ccu_sched_pkg.sv
// Shared types and helpers for the clock-control scheduler: the sequencer
// state encoding and the index-width helper used for slice selects.
package ccu_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        UNG_WAIT  = 3'd1,
        ACK1_WAIT = 3'd2,
        ACK0_WAIT = 3'd3,
        GATE_WAIT = 3'd4
    } ccu_sched_state_e;

    // A single slice still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ccu_sched_rr_arb.sv
// Combinational round-robin pick: first pending slice at or after ptr, wrapping
// around through NUM_SLICES-1 back to 0.
module ccu_sched_rr_arb
    import ccu_sched_pkg::*;
#(
    parameter int NUM_SLICES = 4,
    localparam int IDX_W     = idx_w(NUM_SLICES)
) (
    input  logic [NUM_SLICES-1:0] pend,
    input  logic [IDX_W-1:0]      ptr,
    output logic                  gnt_vld,
    output logic [IDX_W-1:0]      gnt_idx
);

    int k;

    // NOTE: every output of a combinational block gets a default before the
    // conditional logic, otherwise an unassigned path infers a latch.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        k       = 0;
        // Scan the farthest offset first so the nearest pending slice wins.
        for (int i = NUM_SLICES - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NUM_SLICES;
            if (pend[IDX_W'(k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/ccu_clk_sched.sv
// Clock-control scheduler: one shared sequencer walks each slice's gate/ungate
// handshake with programmed edge delays, plus the global and per-slice usync pulses.
module ccu_clk_sched
    import ccu_sched_pkg::*;
#(
    parameter int NUM_SLICES    = 4,
    parameter int REQ1_CLK1_DLY = 2,
    parameter int CLK1_ACK1_DLY = 2,
    parameter int REQ0_ACK0_DLY = 2,
    parameter int ACK0_CLK0_DLY = 8,
    parameter int USYNC_PERIOD  = 16,
    parameter int CNT_W         = 8,
    localparam int IDX_W        = idx_w(NUM_SLICES)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [NUM_SLICES-1:0] clkreq,
    output logic [NUM_SLICES-1:0] clkack,
    output logic [NUM_SLICES-1:0] clk_en,
    output logic [NUM_SLICES-1:0] usync,
    output logic                  globalusync,
    output logic                  busy,
    output logic [IDX_W-1:0]      active_slice
);

    localparam int UCNT_W = idx_w(USYNC_PERIOD);

    localparam logic [CNT_W-1:0]  R1C1_LOAD = CNT_W'(REQ1_CLK1_DLY - 1);
    localparam logic [CNT_W-1:0]  C1A1_LOAD = CNT_W'(CLK1_ACK1_DLY - 1);
    localparam logic [CNT_W-1:0]  R0A0_LOAD = CNT_W'(REQ0_ACK0_DLY - 1);
    localparam logic [CNT_W-1:0]  A0C0_LOAD = CNT_W'(ACK0_CLK0_DLY - 1);
    localparam logic [UCNT_W-1:0] UCNT_LAST = UCNT_W'(USYNC_PERIOD - 1);

    ccu_sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [NUM_SLICES-1:0] ack_d, en_d;
    logic [UCNT_W-1:0]     ucnt_q, ucnt_d;
    logic                  glob_d;
    logic                  gnt_vld;
    logic [IDX_W-1:0]      gnt_idx;

    // A slice is pending whenever its request and acknowledge disagree.
    ccu_sched_rr_arb #(.NUM_SLICES(NUM_SLICES)) u_arb (
        .pend    (clkreq ^ clkack),
        .ptr     (ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        ack_d   = clkack;
        en_d    = clk_en;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    sel_d = gnt_idx;
                    ptr_d = (int'(gnt_idx) == NUM_SLICES - 1) ? '0 : gnt_idx + IDX_W'(1);
                    if (clkreq[gnt_idx]) begin
                        state_d = UNG_WAIT;
                        cnt_d   = R1C1_LOAD;
                    end else begin
                        state_d = ACK0_WAIT;
                        cnt_d   = R0A0_LOAD;
                    end
                end
            end
            UNG_WAIT: begin
                if (cnt_q == '0) begin
                    en_d[sel_q] = 1'b1;
                    state_d     = ACK1_WAIT;
                    cnt_d       = C1A1_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK1_WAIT: begin
                if (cnt_q == '0) begin
                    ack_d[sel_q] = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK0_WAIT: begin
                if (cnt_q == '0) begin
                    ack_d[sel_q] = 1'b0;
                    state_d      = GATE_WAIT;
                    cnt_d        = A0C0_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GATE_WAIT: begin
                if (cnt_q == '0) begin
                    en_d[sel_q] = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // globalusync is registered from the next count so it is high exactly
    // while the counter sits at its last value; usync follows the same edge.
    always_comb begin
        ucnt_d = (ucnt_q == UCNT_LAST) ? '0 : ucnt_q + UCNT_W'(1);
        glob_d = (ucnt_d == UCNT_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            ptr_q       <= '0;
            clkack      <= '0;
            clk_en      <= '0;
            ucnt_q      <= '0;
            globalusync <= 1'b0;
            usync       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            clkack      <= ack_d;
            clk_en      <= en_d;
            ucnt_q      <= ucnt_d;
            globalusync <= glob_d;
            usync       <= {NUM_SLICES{glob_d}} & ack_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign active_slice = busy ? sel_q : '0;

endmodule

// File: tb/tb_ccu_clk_sched.sv
// Self-checking bench for ccu_clk_sched: directed scenarios plus random request
// traffic, all compared against a timestamp-based transaction model.
module tb_ccu_clk_sched;

    localparam int N  = 4;
    localparam int R1 = 2;
    localparam int A1 = 2;
    localparam int R0 = 2;
    localparam int C0 = 8;
    localparam int P  = 16;

    logic         clk    = 1'b0;
    logic         rst_b  = 1'b0;
    logic [N-1:0] clkreq = '0;
    logic [N-1:0] clkack, clk_en, usync;
    logic         globalusync, busy;
    logic [1:0]   active_slice;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ccu_clk_sched #(
        .NUM_SLICES    (N),
        .REQ1_CLK1_DLY (R1),
        .CLK1_ACK1_DLY (A1),
        .REQ0_ACK0_DLY (R0),
        .ACK0_CLK0_DLY (C0),
        .USYNC_PERIOD  (P),
        .CNT_W         (8)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .clkreq       (clkreq),
        .clkack       (clkack),
        .clk_en       (clk_en),
        .usync        (usync),
        .globalusync  (globalusync),
        .busy         (busy),
        .active_slice (active_slice)
    );

    // Transaction model: on grant, the two output changes and the completion
    // are scheduled as absolute edge numbers computed from the delays.
    logic [N-1:0] m_ack, m_en;
    int           m_ptr, m_sel, m_t, m_t1, m_t2;
    bit           m_busy, m_dir;

    function automatic void model_reset();
        m_ack  = '0;
        m_en   = '0;
        m_ptr  = 0;
        m_sel  = 0;
        m_busy = 1'b0;
        m_dir  = 1'b0;
        m_t    = 0;
        m_t1   = 0;
        m_t2   = 0;
    endfunction

    function automatic void model_edge(input logic [N-1:0] req);
        logic [N-1:0] pend;
        int s;
        pend = req ^ m_ack;
        m_t++;
        if (m_busy) begin
            if (m_t == m_t1) begin
                if (m_dir) m_en[m_sel] = 1'b1;
                else       m_ack[m_sel] = 1'b0;
            end
            if (m_t == m_t2) begin
                if (m_dir) m_ack[m_sel] = 1'b1;
                else       m_en[m_sel] = 1'b0;
                m_busy = 1'b0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                s = (m_ptr + k) % N;
                if (!m_busy && pend[s]) begin
                    m_busy = 1'b1;
                    m_sel  = s;
                    m_dir  = req[s];
                    m_ptr  = (s + 1) % N;
                    m_t1   = m_t + (m_dir ? R1 : R0);
                    m_t2   = m_t1 + (m_dir ? A1 : C0);
                end
            end
        end
    endfunction

    function automatic logic [15:0] exp_vec();
        logic glob;
        glob = ((m_t % P) == P - 1);
        return {m_busy, (m_busy ? 2'(m_sel) : 2'd0), glob, ({N{glob}} & m_ack), m_en, m_ack};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {busy, active_slice, globalusync, usync, clk_en, clkack};
    endfunction

    // One clock edge for DUT and model; returns at the following falling edge.
    task automatic step();
        @(posedge clk);
        model_edge(clkreq);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_vec() !== 16'h0000)
            $display("FAIL reset_state: got %h expected 0000", dut_vec());
        else n_pass++;
        rst_b = 1'b1;
        model_reset();
        for (int j = 1; j <= 6; j++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL reset_idle cyc %0d: got %h expected %h", j, dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_ungate();
        bit ok;
        clkreq[1] = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL ungate cyc %0d: got %h expected %h", j, dut_vec(), exp_vec());
            else n_pass++;
            ok = 1'b1;
            case (j)
                1: ok = (busy === 1'b1) && (active_slice === 2'd1);
                2: ok = (clk_en[1] === 1'b0);
                3: ok = (clk_en[1] === 1'b1) && (clkack[1] === 1'b0);
                5: ok = (clkack[1] === 1'b1) && (busy === 1'b0);
                default: ok = 1'b1;
            endcase
            if (j inside {1, 2, 3, 5}) begin
                n_checks++;
                if (!ok)
                    $display("FAIL ungate_timing cyc %0d: got busy=%b act=%0d en=%b ack=%b", j, busy, active_slice, clk_en, clkack);
                else n_pass++;
            end
        end
    endtask

    task automatic test_gate();
        bit ok;
        clkreq[1] = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL gate cyc %0d: got %h expected %h", j, dut_vec(), exp_vec());
            else n_pass++;
            ok = 1'b1;
            case (j)
                1:  ok = (busy === 1'b1) && (active_slice === 2'd1) && (clkack[1] === 1'b1);
                3:  ok = (clkack[1] === 1'b0) && (clk_en[1] === 1'b1);
                10: ok = (clk_en[1] === 1'b1);
                11: ok = (clk_en[1] === 1'b0) && (busy === 1'b0);
                default: ok = 1'b1;
            endcase
            if (j inside {1, 3, 10, 11}) begin
                n_checks++;
                if (!ok)
                    $display("FAIL gate_timing cyc %0d: got busy=%b en=%b ack=%b", j, busy, clk_en, clkack);
                else n_pass++;
            end
        end
    endtask

    task automatic test_all_rise();
        int rise_at [N];
        clkreq = '0;
        do_reset();
        foreach (rise_at[i]) rise_at[i] = -1;
        clkreq = '1;
        for (int j = 1; j <= 25; j++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL all_rise cyc %0d: got %h expected %h", j, dut_vec(), exp_vec());
            else n_pass++;
            for (int i = 0; i < N; i++)
                if (rise_at[i] < 0 && clkack[i] === 1'b1) rise_at[i] = j;
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (rise_at[i] != 5 + 5 * i)
                $display("FAIL all_rise_order slice %0d: got ack at cyc %0d expected %0d", i, rise_at[i], 5 + 5 * i);
            else n_pass++;
        end
    endtask

    task automatic test_drop_inflight();
        bit ok;
        clkreq = '0;
        do_reset();
        clkreq[2] = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL drop_inflight cyc %0d: got %h expected %h", j, dut_vec(), exp_vec());
            else n_pass++;
            if (j == 1) clkreq[2] = 1'b0;
            ok = 1'b1;
            case (j)
                5:  ok = (clkack[2] === 1'b1) && (busy === 1'b0);
                6:  ok = (busy === 1'b1) && (active_slice === 2'd2);
                8:  ok = (clkack[2] === 1'b0);
                15: ok = (clk_en[2] === 1'b1);
                16: ok = (clk_en[2] === 1'b0);
                default: ok = 1'b1;
            endcase
            if (j inside {5, 6, 8, 15, 16}) begin
                n_checks++;
                if (!ok)
                    $display("FAIL drop_timing cyc %0d: got busy=%b act=%0d en=%b ack=%b", j, busy, active_slice, clk_en, clkack);
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        clkreq = '0;
        do_reset();
        clkreq[0] = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL async_pre cyc %0d: got %h expected %h", j, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (clk_en[0] !== 1'b1 || busy !== 1'b1)
            $display("FAIL async_setup: got en=%b busy=%b expected en[0]=1 busy=1", clk_en, busy);
        else n_pass++;
        #2;
        rst_b = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== 16'h0000)
            $display("FAIL async_clear: got %h expected 0000", dut_vec());
        else n_pass++;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL async_post cyc %0d: got %h expected %h", j, dut_vec(), exp_vec());
            else n_pass++;
            if (j == 3 || j == 5) begin
                n_checks++;
                if ((j == 3 && clk_en[0] !== 1'b1) || (j == 5 && clkack[0] !== 1'b1))
                    $display("FAIL async_reungate cyc %0d: got en=%b ack=%b", j, clk_en, clkack);
                else n_pass++;
            end
        end
    endtask

    task automatic test_usync();
        int pulses;
        int last;
        clkreq = '0;
        do_reset();
        clkreq = 4'b0101;
        pulses = 0;
        last   = -1;
        for (int j = 1; j <= 60; j++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL usync cyc %0d: got %h expected %h", j, dut_vec(), exp_vec());
            else n_pass++;
            if (j > 12 && globalusync === 1'b1) begin
                n_checks++;
                if (usync !== 4'b0101 || (last >= 0 && j - last != P))
                    $display("FAIL usync_pulse cyc %0d: got usync=%b gap=%0d expected 0101 gap=%0d", j, usync, j - last, P);
                else n_pass++;
                last = j;
                pulses++;
            end
        end
        n_checks++;
        if (pulses != 3)
            $display("FAIL usync_count: got %0d pulses expected 3", pulses);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int j = 1; j <= 1500; j++) begin
            if ($urandom_range(0, 5) == 0) clkreq[$urandom_range(0, N - 1)] ^= 1'b1;
            step();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL random cyc %0d: got %h expected %h", j, dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ungate();
        test_gate();
        test_all_rise();
        test_drop_inflight();
        test_async_reset();
        test_usync();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
